orb_packer_n: RTL

Multi-channel packer that captures bytes from NCH asynchronous strobed sources and formats each into a telemetry word. It produces per-channel write-enable/address pairs that interleave all channels into one orbital-frame RAM. It generalises the two-channel packer in channel count, data/word/address width, words per package and write-enable timing, and adds per-channel enable masking and a pack-complete pulse. Sits between the serial byte receivers and the dual-port frame RAM write side.

---
 rtl/orb_packer_n.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/orb_packer_n.sv
// orb_packer_n: captures strobed bytes from NCH channels and writes them as telemetry words
// interleaved into one orbital-frame RAM. Define ORB_PARITY_EN to put odd parity in the word MSB.
module orb_packer_n #(
    parameter int NCH      = 2,
    parameter int DW       = 8,
    parameter int WW       = 12,
    parameter int AW       = 11,
    parameter int WPP      = 16,
    parameter int GAP      = 2,
    parameter int WE_DELAY = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*DW-1:0] iData,
    input  logic [NCH-1:0]    strob,
    input  logic [NCH-1:0]    chEn,
    input  logic              SW,
    output logic              test,
    output logic [NCH*WW-1:0] orbWord,
    output logic [NCH-1:0]    WE,
    output logic [NCH*AW-1:0] WrAddr,
    output logic [NCH-1:0]    packDone
);

    localparam int WRDW = $clog2(WPP + GAP);
    localparam int SLW  = $clog2(WPP + 1);

    typedef enum logic [1:0] {IDLE, ARM, WRITE, SKIP} state_t;

    logic swS1, swS2, swPrev, swEdge;

    always_ff @(posedge clk) begin
        swS1 <= SW;
        swS2 <= swS1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            swPrev <= 1'b0;
            test   <= 1'b0;
        end else begin
            swPrev <= swS2;
            test   <= swEdge;
        end
    end

    assign swEdge = swS2 ^ swPrev;

    for (genvar c = 0; c < NCH; c++) begin : gCh
        logic            sS1, sS2;
        state_t          st, stN;
        logic [WRDW-1:0] wrd, wrdN;
        logic [SLW-1:0]  slot, slotN;
        logic [AW-1:0]   pack, packN, addrQ, addrN;
        logic [7:0]      dly, dlyN;
        logic [WW-1:0]   wordQ, wordN;
        logic            weQ, weN, doneQ, doneN;
        logic [DW-1:0]   din;
        logic            par;

        assign din = iData[c*DW +: DW];
`ifdef ORB_PARITY_EN
        assign par = ~^din;
`else
        assign par = 1'b0;
`endif

        always_ff @(posedge clk) begin
            sS1 <= strob[c];
            sS2 <= sS1;
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                st    <= IDLE;
                wrd   <= '0;
                slot  <= '0;
                pack  <= '0;
                dly   <= '0;
                addrQ <= '0;
                wordQ <= '0;
                weQ   <= 1'b0;
                doneQ <= 1'b0;
            end else begin
                st    <= stN;
                wrd   <= wrdN;
                slot  <= slotN;
                pack  <= packN;
                dly   <= dlyN;
                addrQ <= addrN;
                wordQ <= wordN;
                weQ   <= weN;
                doneQ <= doneN;
            end
        end

        // Restart from an SW edge takes priority over any capture in the same cycle.
        always_comb begin
            stN   = st;
            wrdN  = wrd;
            slotN = slot;
            packN = pack;
            dlyN  = dly;
            addrN = addrQ;
            wordN = wordQ;
            weN   = weQ;
            doneN = 1'b0;
            if (swEdge) begin
                stN   = SKIP;
                wrdN  = '0;
                slotN = '0;
                packN = '0;
                dlyN  = '0;
                weN   = 1'b0;
            end else begin
                case (st)
                    IDLE: begin
                        if (sS2 && chEn[c]) begin
                            if (wrd < WRDW'(WPP)) begin
                                wordN = WW'({par, din}) << (WW - DW - 1);
                                addrN = AW'(32'(pack) * 32'(NCH * WPP) + 32'(slot) * 32'(NCH) + 32'(c));
                                slotN = slot + 1'b1;
                                wrdN  = wrd + 1'b1;
                                dlyN  = '0;
                                stN   = ARM;
                            end else if (wrd == WRDW'(WPP + GAP - 1)) begin
                                wrdN  = '0;
                                slotN = '0;
                                packN = pack + 1'b1;
                                doneN = 1'b1;
                                stN   = SKIP;
                            end else begin
                                wrdN  = wrd + 1'b1;
                                stN   = SKIP;
                            end
                        end
                    end
                    ARM: begin
                        dlyN = dly + 8'd1;
                        if (dly == 8'(WE_DELAY - 1)) begin
                            weN = 1'b1;
                            stN = WRITE;
                        end
                    end
                    WRITE: begin
                        if (!sS2) begin
                            weN = 1'b0;
                            stN = IDLE;
                        end
                    end
                    default: begin
                        if (!sS2) stN = IDLE;
                    end
                endcase
            end
        end

        assign WE[c]                = weQ;
        assign packDone[c]          = doneQ;
        assign orbWord[c*WW +: WW]  = wordQ;
        assign WrAddr[c*AW +: AW]   = addrQ;
    end

endmodule
